servo_pwm_gen: RTL and testbench
================================

// Module: servo_pwm_gen
// PURPOSE
//  Downstream of the lock's angle-select stage: converts an 8-bit target angle (degrees)
//  into a standard 50 Hz hobby-servo PWM waveform on one pin.
//  Angle changes are taken only at PWM frame boundaries, so a pulse is never cut short or
//  stretched. Optional slew limiting moves the horn gradually toward the target.
// PARAMETERS
//  CLK_FREQ      12_000_000  system clock, Hz
//  PWM_FREQ      50          frame rate, Hz; FRAME_TICKS = CLK_FREQ/PWM_FREQ = 240_000
//  MIN_PULSE_US  500         pulse width at 0 deg; MIN_TICKS = 6_000
//  MAX_PULSE_US  2500        pulse width at MAX_ANGLE; MAX_TICKS = 30_000
//  MAX_ANGLE     180         largest legal angle; larger inputs are clamped
//  RESET_ANGLE   90          applied angle after reset (lock closed)
//  SLEW_STEP     2           deg per frame, used only when SERVO_SLEW_EN is defined
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-high reset
//  en            in   1  1 = drive pulses; 0 = hold pwm_out low, frame counter keeps running
//  target_angle  in   8  requested angle, deg, unsigned
//  pwm_out       out  1  servo control signal
//  frame_start   out  1  one-cycle strobe on the first cycle of each frame
//  cur_angle     out  8  angle used for the current frame
//  at_target     out  1  1 when cur_angle == clamped target_angle
// BEHAVIOUR
//  - Reset (async, active-high): frame_cnt=0, pwm_out=0, frame_start=0, cur_angle=RESET_ANGLE,
//    at_target=0, state=IDLE. Asserting rst mid-pulse drops pwm_out in the same instant.
//  - frame_cnt: 0..FRAME_TICKS-1, wraps to 0. frame_start=1 in the cycle frame_cnt==0.
//  - Boundary update, registered in the cycle frame_cnt wraps to 0:
//    - tgt_c = min(target_angle, MAX_ANGLE).
//    - cur_angle is set to the next angle, see CONFIGURATION.
//    - pulse_ticks = MIN_TICKS + next_angle*DEG_TICKS,
//      DEG_TICKS = (MAX_TICKS-MIN_TICKS)/MAX_ANGLE, integer floor = 133.
//    - Product width 8x8 -> 16 bit; sum fits 18 bit. Samples: 0->6000, 40->11320,
//      90->17970, 180->29940 ticks.
//  - target_angle is ignored outside the boundary cycle. Mid-frame changes have no effect
//    until the next frame.
//  - FSM, evaluated at the frame boundary:
//    - IDLE: pwm_out=0. At a boundary with en=1 -> HIGH.
//    - HIGH: pwm_out=1 while frame_cnt < pulse_ticks. Then -> LOW.
//    - LOW: pwm_out=0. At a boundary: en=1 -> HIGH, en=0 -> IDLE.
//    - en falling mid-pulse does not truncate the pulse; it takes effect at the next boundary.
//  - pwm_out is registered: high from the cycle after frame_cnt==0 for exactly pulse_ticks
//    cycles, i.e. 1 cycle of latency.
//  - at_target updates together with cur_angle.
// CONFIGURATION
//  SERVO_SLEW_EN defined:
//    - Each boundary moves cur_angle toward tgt_c by at most SLEW_STEP.
//    - If |tgt_c-cur_angle| <= SLEW_STEP, cur_angle = tgt_c, with no overshoot and no
//      8-bit wrap (compare before subtract).
//  SERVO_SLEW_EN undefined:
//    - cur_angle = tgt_c at every boundary; SLEW_STEP is unused.
// TESTING
//  1 Reset then release, en=1, target=90: first pulse 17970 clk high, period 240000 clk,
//    at_target=1 after first frame_start.
//  2 target=40 for 1 frame, then target=0 and target=180: pulse widths 11320 / 6000 / 29940
//    clk; target=200 gives 29940 and cur_angle=180.
//  3 Change target 90->40 at frame_cnt=5000: the current pulse stays 17970, the next pulse
//    is 11320, no glitch on pwm_out.
//  4 en=0 at frame_cnt=1000: the current pulse completes at 17970 clk, then pwm_out stays
//    low. en=1 again: pulses resume at the next boundary.
//  5 rst pulse at frame_cnt=8000 mid-pulse: pwm_out=0 immediately, cur_angle=90, the
//    counter restarts at 0.
//  6 SERVO_SLEW_EN, target 90->40, SLEW_STEP=2: cur_angle 88, 86, ... 40 over 25 frames;
//    at_target=0 until it reaches 40. Undefined build: 40 in one frame.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: 8-bit angle in, one pulse per frame out, angle latched at frame boundaries.
// Optional slew limiting of the applied angle is enabled by defining SERVO_SLEW_EN.
module servo_pwm_gen #(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned PWM_FREQ     = 50,
  parameter int unsigned MIN_PULSE_US = 500,
  parameter int unsigned MAX_PULSE_US = 2500,
  parameter int unsigned MAX_ANGLE    = 180,
  parameter int unsigned RESET_ANGLE  = 90,
  parameter int unsigned SLEW_STEP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] target_angle,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] cur_angle,
  output logic       at_target
);

  localparam int unsigned ANG_W        = 8;
  localparam int unsigned PROD_W       = 16;
  localparam int unsigned FRAME_TICKS  = CLK_FREQ / PWM_FREQ;
  localparam int unsigned TICKS_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned MIN_TICKS    = TICKS_PER_MS * MIN_PULSE_US / 1000;
  localparam int unsigned MAX_TICKS    = TICKS_PER_MS * MAX_PULSE_US / 1000;
  localparam int unsigned DEG_TICKS    = (MAX_TICKS - MIN_TICKS) / MAX_ANGLE;
  localparam int unsigned CNT_W        = $clog2(FRAME_TICKS);
  localparam int unsigned RESET_TICKS  = MIN_TICKS + RESET_ANGLE * DEG_TICKS;

  // Largest angle change allowed per frame; a step spanning the whole range means "jump".
`ifdef SERVO_SLEW_EN
  localparam int unsigned STEP = SLEW_STEP;
`else
  localparam int unsigned STEP = (SLEW_STEP > MAX_ANGLE) ? SLEW_STEP : MAX_ANGLE;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   pulse_ticks;
  logic               boundary_c;
  logic               pwm_nxt;
  logic [ANG_W-1:0]   tgt_c;
  logic [ANG_W-1:0]   next_angle_c;
  logic [PROD_W-1:0]  prod_c;
  logic [CNT_W-1:0]   pulse_nxt_c;

  assign boundary_c = (frame_cnt == CNT_W'(FRAME_TICKS - 1));
  assign tgt_c      = (target_angle > ANG_W'(MAX_ANGLE)) ? ANG_W'(MAX_ANGLE) : target_angle;

  // Move toward the target by at most STEP; distances are compared before subtracting.
  always_comb begin
    next_angle_c = tgt_c;
    if (tgt_c > cur_angle) begin
      if ((tgt_c - cur_angle) > ANG_W'(STEP)) next_angle_c = cur_angle + ANG_W'(STEP);
    end else if (tgt_c < cur_angle) begin
      if ((cur_angle - tgt_c) > ANG_W'(STEP)) next_angle_c = cur_angle - ANG_W'(STEP);
    end
  end

  assign prod_c      = PROD_W'(next_angle_c) * PROD_W'(DEG_TICKS);
  assign pulse_nxt_c = CNT_W'(MIN_TICKS) + CNT_W'(prod_c);

  // Free-running frame counter and first-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_cnt   <= boundary_c ? '0 : frame_cnt + CNT_W'(1);
      frame_start <= boundary_c;
    end
  end

  // Angle and pulse width are only refreshed as the counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_angle   <= ANG_W'(RESET_ANGLE);
      pulse_ticks <= CNT_W'(RESET_TICKS);
      at_target   <= 1'b0;
    end else if (boundary_c) begin
      cur_angle   <= next_angle_c;
      pulse_ticks <= pulse_nxt_c;
      at_target   <= (next_angle_c == tgt_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pwm_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      pwm_out <= pwm_nxt;
    end
  end

  // en is only consulted at the boundary so a started pulse always completes.
  always_comb begin
    state_nxt = state;
    pwm_nxt   = 1'b0;
    case (state)
      IDLE: if (boundary_c && en) state_nxt = HIGH;
      HIGH: begin
        if (frame_cnt < pulse_ticks) pwm_nxt = 1'b1;
        else                         state_nxt = LOW;
      end
      LOW:  if (boundary_c) state_nxt = en ? HIGH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with a scaled clock (600 kHz, 250 Hz frames: 2400 ticks/frame,
// 300 + 6*angle ticks of pulse) so every frame can be walked cycle by cycle.
module tb_servo_pwm_gen;

  localparam int FRAME = 2400;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] target_angle;
  logic       pwm_out;
  logic       frame_start;
  logic [7:0] cur_angle;
  logic       at_target;

  int n_total = 0;
  int n_pass  = 0;

  servo_pwm_gen #(
    .CLK_FREQ(600_000), .PWM_FREQ(250), .MIN_PULSE_US(500), .MAX_PULSE_US(2500),
    .MAX_ANGLE(180), .RESET_ANGLE(90), .SLEW_STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .target_angle(target_angle),
    .pwm_out(pwm_out), .frame_start(frame_start), .cur_angle(cur_angle), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tgt;
    int         chg_at;
    logic [7:0] cur;
    logic       at;
    int         width;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Walks one frame from a cnt==0 negedge to the next one, optionally changing inputs mid-frame.
  task automatic run_frame(input int chg_at, input logic [7:0] tgt, input int en_at,
                           input logic en_val, output int width, output int rises,
                           output logic fs);
    logic prev;
    width = 0;
    rises = 0;
    prev  = pwm_out;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (pwm_out) width++;
      if (pwm_out && !prev) rises++;
      prev = pwm_out;
      if (i == chg_at) target_angle = tgt;
      if (i == en_at) en = en_val;
    end
    @(negedge clk);
    fs = frame_start;
  endtask

  initial begin
    int   w, r, prev_w;
    logic fs;

    vecs[0] = '{tgt: 8'd40,  chg_at: 100,  cur: 8'd40,  at: 1'b1, width: 540};
    vecs[1] = '{tgt: 8'd0,   chg_at: 100,  cur: 8'd0,   at: 1'b1, width: 300};
    vecs[2] = '{tgt: 8'd180, chg_at: 100,  cur: 8'd180, at: 1'b1, width: 1380};
    vecs[3] = '{tgt: 8'd200, chg_at: 100,  cur: 8'd180, at: 1'b1, width: 1380};
    vecs[4] = '{tgt: 8'd90,  chg_at: 100,  cur: 8'd90,  at: 1'b1, width: 840};
    vecs[5] = '{tgt: 8'd40,  chg_at: 500,  cur: 8'd40,  at: 1'b1, width: 540};
    vecs[6] = '{tgt: 8'd180, chg_at: 2390, cur: 8'd180, at: 1'b1, width: 1380};

    rst = 1'b1;
    en = 1'b1;
`ifdef SERVO_SLEW_EN
    target_angle = 8'd40;
`else
    target_angle = 8'd90;
`endif
    repeat (3) @(negedge clk);
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset frame_start", int'(frame_start), 0);
    chk("reset cur_angle", int'(cur_angle), 90);
    chk("reset at_target", int'(at_target), 0);
    rst = 1'b0;

    // First frame after reset is IDLE: no pulse.
    run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
    chk("idle frame width", w, 0);
    chk("first frame_start", int'(fs), 1);

`ifdef SERVO_SLEW_EN
    chk("slew first cur_angle", int'(cur_angle), 88);
    chk("slew first at_target", int'(at_target), 0);
    for (int k = 2; k <= 25; k++) begin
      run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
      chk("slew frame_start", int'(fs), 1);
      chk("slew cur_angle", int'(cur_angle), 90 - 2 * k);
      chk("slew at_target", int'(at_target), (k == 25) ? 1 : 0);
    end
    run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
    chk("slew final width", w, 540);
`else
    chk("t1 cur_angle", int'(cur_angle), 90);
    chk("t1 at_target", int'(at_target), 1);

    // Each frame applies the next target and checks the pulse of the previous one.
    prev_w = 840;
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].chg_at, vecs[i].tgt, -1, 1'b0, w, r, fs);
      chk($sformatf("vec%0d width", i), w, prev_w);
      chk($sformatf("vec%0d rises", i), r, 1);
      chk($sformatf("vec%0d period", i), int'(fs), 1);
      chk($sformatf("vec%0d cur_angle", i), int'(cur_angle), int'(vecs[i].cur));
      chk($sformatf("vec%0d at_target", i), int'(at_target), int'(vecs[i].at));
      prev_w = vecs[i].width;
    end

    // en dropped mid-pulse: pulse completes, next frame silent, resumes after re-enable.
    run_frame(-1, 8'd0, 100, 1'b0, w, r, fs);
    chk("en-off pulse width", w, 1380);
    run_frame(-1, 8'd0, 100, 1'b1, w, r, fs);
    chk("en-off silent frame", w, 0);
    run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
    chk("en-on resumed width", w, 1380);
    chk("en-on frame_start", int'(fs), 1);

    // Reset in the middle of a pulse.
    repeat (800) @(negedge clk);
    chk("pre-rst pwm_out", int'(pwm_out), 1);
    rst = 1'b1;
    #1;
    chk("rst async pwm_out", int'(pwm_out), 0);
    chk("rst cur_angle", int'(cur_angle), 90);
    chk("rst at_target", int'(at_target), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
    chk("post-rst idle width", w, 0);
    chk("post-rst restart period", int'(fs), 1);
    chk("post-rst cur_angle", int'(cur_angle), 180);

    // Unslewed build jumps 180 -> 40 in one frame.
    run_frame(100, 8'd40, -1, 1'b0, w, r, fs);
    chk("jump old width", w, 1380);
    chk("jump cur_angle", int'(cur_angle), 40);
    chk("jump at_target", int'(at_target), 1);
    run_frame(-1, 8'd0, -1, 1'b0, w, r, fs);
    chk("jump new width", w, 540);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
